// File: rtl/bk_stream_accumulator_pkg.sv
// rtl/bk_stream_accumulator_pkg.sv - shared constants, FSM state type and saturating increment
package bk_stream_accumulator_pkg;

    localparam int DATA_W = 32;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Callers pass the counter zero-extended to 32 bits and truncate the result back.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
        return (value == max_value) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/bk_stream_accumulator_if.sv
// rtl/bk_stream_accumulator_if.sv - operand input stream and result output stream
interface bk_stream_accumulator_if #(parameter int CNT_W = 8);
    import bk_stream_accumulator_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_sum;
    logic [CNT_W-1:0]  out_carries;
    logic [CNT_W-1:0]  out_count;
    logic              out_cnt_sat;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_carries, out_count, out_cnt_sat
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_carries, out_count, out_cnt_sat
    );
endinterface

// File: rtl/bk_stream_accumulator_adder.sv
// rtl/bk_stream_accumulator_adder.sv - combinational 32-bit Brent-Kung adder
module bk_stream_accumulator_adder
    import bk_stream_accumulator_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    output logic [DATA_W-1:0] s,
    output logic              cout
);
    logic [DATA_W-1:0] w_p;
    logic [DATA_W-1:0] w_gg;
    logic [DATA_W-1:0] w_pp;

    // In-place prefix tree: up-sweep builds power-of-two spans, down-sweep fills the gaps.
    always_comb begin
        w_p   = a ^ b;
        w_gg  = a & b;
        w_pp  = w_p;
        w_gg[0] = (a[0] & b[0]) | (w_p[0] & cin);
        for (int d = 1; d < DATA_W; d = d * 2) begin
            for (int i = 2 * d - 1; i < DATA_W; i = i + 2 * d) begin
                w_gg[i] = w_gg[i] | (w_pp[i] & w_gg[i-d]);
                w_pp[i] = w_pp[i] & w_pp[i-d];
            end
        end
        for (int d = DATA_W / 4; d >= 1; d = d / 2) begin
            for (int i = 3 * d - 1; i < DATA_W; i = i + 2 * d) begin
                w_gg[i] = w_gg[i] | (w_pp[i] & w_gg[i-d]);
                w_pp[i] = w_pp[i] & w_pp[i-d];
            end
        end
    end

    assign s    = w_p ^ {w_gg[DATA_W-2:0], cin};
    assign cout = w_gg[DATA_W-1];
endmodule

// File: rtl/bk_stream_accumulator.sv
// rtl/bk_stream_accumulator.sv - framed streaming accumulator with carry and operand counters
module bk_stream_accumulator
    import bk_stream_accumulator_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    bk_stream_accumulator_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_acc;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_carries;
    logic              r_sat;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_sum;
    logic [CNT_W-1:0]  r_out_carries;
    logic [CNT_W-1:0]  r_out_count;
    logic              r_out_sat;

    logic [DATA_W-1:0] w_sum;
    logic              w_cout;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [CNT_W-1:0]  w_carries_nxt;
    logic              w_sat_nxt;
    logic              w_in_ready;
    logic              w_accept;

    bk_stream_accumulator_adder u_adder (
        .a    (r_acc),
        .b    (bus.in_data),
        .cin  (1'b0),
        .s    (w_sum),
        .cout (w_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ACCUM;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ACCUM:   if (w_accept && bus.in_last)       w_state_nxt = HOLD;
            HOLD:    if (r_out_valid && bus.out_ready)  w_state_nxt = ACCUM;
            default: w_state_nxt = ACCUM;
        endcase
    end

    always_comb begin
        w_in_ready = ~r_out_valid;
        w_accept   = bus.in_valid & w_in_ready & (r_state == ACCUM);
    end

    always_comb begin
        w_count_nxt   = CNT_W'(sat_inc(32'(r_count), 32'(CNT_MAX)));
        w_carries_nxt = w_cout ? CNT_W'(sat_inc(32'(r_carries), 32'(CNT_MAX))) : r_carries;
        w_sat_nxt     = r_sat | (r_count == CNT_MAX) | (w_cout & (r_carries == CNT_MAX));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc         <= '0;
            r_count       <= '0;
            r_carries     <= '0;
            r_sat         <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_sum     <= '0;
            r_out_carries <= '0;
            r_out_count   <= '0;
            r_out_sat     <= 1'b0;
        end else if (w_accept) begin
            if (bus.in_last) begin
                r_out_sum     <= w_sum;
                r_out_carries <= w_carries_nxt;
                r_out_count   <= w_count_nxt;
                r_out_sat     <= w_sat_nxt;
                r_out_valid   <= 1'b1;
                r_acc         <= '0;
                r_count       <= '0;
                r_carries     <= '0;
                r_sat         <= 1'b0;
            end else begin
                r_acc         <= w_sum;
                r_count       <= w_count_nxt;
                r_carries     <= w_carries_nxt;
                r_sat         <= w_sat_nxt;
            end
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_sum     = r_out_sum;
    assign bus.out_carries = r_out_carries;
    assign bus.out_count   = r_out_count;
    assign bus.out_cnt_sat = r_out_sat;
endmodule

// File: tb/tb_bk_stream_accumulator.sv
// tb/tb_bk_stream_accumulator.sv - scoreboard bench for bk_stream_accumulator
module tb_bk_stream_accumulator;
    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    typedef struct packed {
        logic [31:0] sum;
        logic [7:0]  car;
        logic [7:0]  cnt;
        logic        sat;
    } exp_t;

    exp_t q8[$];
    exp_t q2[$];

    bk_stream_accumulator_if #(.CNT_W(8)) if8 ();
    bk_stream_accumulator_if #(.CNT_W(2)) if2 ();

    bk_stream_accumulator #(.CNT_W(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));
    bk_stream_accumulator #(.CNT_W(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] s, input logic [7:0] c, input logic [7:0] n, input logic t);
        exp_t e;
        e.sum = s; e.car = c; e.cnt = n; e.sat = t;
        return e;
    endfunction

    // Monitors: one comparison per output handshake.
    always @(negedge clk) begin
        if (!rst && if8.out_valid && if8.out_ready) begin
            if (q8.size() == 0) check("dut8_unexpected_result", 64'd1, 64'd0);
            else check("dut8_result",
                       64'(mk(if8.out_sum, if8.out_carries, if8.out_count, if8.out_cnt_sat)),
                       64'(q8.pop_front()));
        end
        if (!rst && if2.out_valid && if2.out_ready) begin
            if (q2.size() == 0) check("dut2_unexpected_result", 64'd1, 64'd0);
            else check("dut2_result",
                       64'(mk(if2.out_sum, 8'(if2.out_carries), 8'(if2.out_count), if2.out_cnt_sat)),
                       64'(q2.pop_front()));
        end
    end

    task automatic send8(input logic [31:0] d, input logic l);
        int n = 0;
        @(negedge clk);
        if8.in_valid = 1'b1; if8.in_data = d; if8.in_last = l;
        while (!if8.in_ready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) check("dut8_send_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
        if8.in_valid = 1'b0;
    endtask

    task automatic send2(input logic [31:0] d, input logic l);
        int n = 0;
        @(negedge clk);
        if2.in_valid = 1'b1; if2.in_data = d; if2.in_last = l;
        while (!if2.in_ready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) check("dut2_send_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
        if2.in_valid = 1'b0;
    endtask

    task automatic drain8();
        int n = 0;
        while (if8.out_valid && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) check("dut8_drain_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        if8.in_valid = 1'b0; if8.in_data = '0; if8.in_last = 1'b0; if8.out_ready = 1'b1;
        if2.in_valid = 1'b0; if2.in_data = '0; if2.in_last = 1'b0; if2.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 1: load a held result, then async reset mid-cycle must clear it at once
        if8.out_ready = 1'b0;
        send8(32'd50, 1'b1);
        check("pre_reset_valid", 64'(if8.out_valid), 64'd1);
        check("pre_reset_sum", 64'(if8.out_sum), 64'd50);
        #2 rst = 1'b1;
        #1;
        check("async_reset_valid_ready", {62'd0, if8.out_valid, if8.in_ready}, 64'b01);
        check("async_reset_outputs",
              64'(mk(if8.out_sum, if8.out_carries, if8.out_count, if8.out_cnt_sat)), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        if8.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("idle_ready_valid", {62'd0, if8.in_ready, if8.out_valid}, 64'b10);
        end

        // 2: back-to-back frame with latency check
        q8.push_back(mk(32'd6, 8'd0, 8'd3, 1'b0));
        send8(32'd1, 1'b0);
        send8(32'd2, 1'b0);
        check("latency_no_early_valid", 64'(if8.out_valid), 64'd0);
        send8(32'd3, 1'b1);
        check("latency_valid_after_last", {62'd0, if8.out_valid, if8.in_ready}, 64'b10);

        // 3: wrap produces one carry, bubble between beats 1 and 2
        q8.push_back(mk(32'hFFFF_FFFF, 8'd1, 8'd3, 1'b0));
        send8(32'hFFFF_FFFF, 1'b0);
        @(posedge clk); #1;
        send8(32'h0000_0001, 1'b0);
        send8(32'hFFFF_FFFF, 1'b1);

        // 4: backpressure holds outputs and blocks input
        @(posedge clk); #1;
        drain8();
        if8.out_ready = 1'b0;
        q8.push_back(mk(32'd5, 8'd0, 8'd1, 1'b0));
        send8(32'd5, 1'b1);
        if8.in_valid = 1'b1; if8.in_data = 32'd9; if8.in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold_ready_valid", {62'd0, if8.in_ready, if8.out_valid}, 64'b01);
            check("hold_outputs",
                  64'(mk(if8.out_sum, if8.out_carries, if8.out_count, if8.out_cnt_sat)),
                  64'(mk(32'd5, 8'd0, 8'd1, 1'b0)));
        end
        if8.in_valid = 1'b0;
        if8.out_ready = 1'b1;
        @(posedge clk); #1;
        check("hold_released", {62'd0, if8.in_ready, if8.out_valid}, 64'b10);
        q8.push_back(mk(32'd9, 8'd0, 8'd1, 1'b0));
        send8(32'd9, 1'b1);

        // 5: narrow counters saturate, flag does not leak into the next frame
        q2.push_back(mk(32'd5, 8'd0, 8'd3, 1'b1));
        for (int i = 0; i < 5; i++) send2(32'd1, (i == 4));
        q2.push_back(mk(32'd4, 8'd0, 8'd1, 1'b0));
        send2(32'd4, 1'b1);

        // 6: reset mid-frame discards partial sum
        @(posedge clk); #1;
        drain8();
        send8(32'd100, 1'b0);
        send8(32'd200, 1'b0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        q8.push_back(mk(32'd7, 8'd0, 8'd1, 1'b0));
        send8(32'd7, 1'b1);

        n = 0;
        while ((q8.size() != 0 || q2.size() != 0) && n < 200) begin @(posedge clk); n++; end
        check("scoreboard_empty", 64'(q8.size() + q2.size()), 64'd0);
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/bk_stream_accumulator.md
# bk_stream_accumulator

Streaming 32-bit accumulator that sits directly downstream of the team's combinational 32-bit Brent-Kung adder and drives it every accepted beat. It sums a frame of operands delivered over a valid/ready stream and counts carry-outs and operands. At the frame's last beat it presents one registered result on a valid/ready output.

## Interface
- `CNT_W`, default 8: width of the operand and carry counters; both saturate at 2^CNT_W-1.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: operand beat valid.
- `in_ready` output 1: block accepts a beat; equals `~out_valid`.
- `in_data` input 32: operand.
- `in_last` input 1: the beat is the final operand of the frame.
- `out_valid` output 1: result valid; held until accepted.
- `out_ready` input 1: downstream accepts the result.
- `out_sum` output 32: modulo-2^32 frame sum.
- `out_carries` output CNT_W: number of adder carry-outs in the frame, saturating.
- `out_count` output CNT_W: number of operands in the frame, saturating.
- `out_cnt_sat` output 1: sticky flag; set if either counter saturated during the frame.

## Operation
- Two states: ACCUM and HOLD. Reset state is ACCUM.
- **ACCUM:**
  - Accept occurs when `in_valid & in_ready`.
  - On accept: `acc <= acc + in_data` through the adder with cin=0.
  - On accept: `carries` increments if the adder's cout=1.
  - On accept: `count` increments.
  - A counter already at max stays at max and sets the sat flag.
  - `in_valid=0` is a bubble; no state changes.
- **Accept with `in_last=1`:**
  - The updated sum and counters load into the output registers.
  - `out_valid` is set and the state moves to HOLD.
  - Working accumulators clear to 0 in the same edge.
- **HOLD:**
  - `in_ready=0` and `in_*` are ignored.
  - All `out_*` stay stable until `out_valid & out_ready`.
  - On that handshake: `out_valid` clears and the state returns to ACCUM.
- A single-beat frame (`in_last` on the first beat) yields `out_sum=in_data`, `out_count=1`, `out_carries=0`.
- Operands are unsigned. The carry count is the number of 2^32 wraps, so the true sum is `out_sum + out_carries*2^32` unless `out_cnt_sat=1`.
- Reset in mid-frame or mid-HOLD discards all partial state, including any result not yet accepted.

## Timing
- Reset values:
  - `out_valid=0`, `in_ready=1`.
  - `out_sum=0`, `out_carries=0`, `out_count=0`, `out_cnt_sat=0`.
  - Internal acc, counters and sat flag = 0; state = ACCUM.
- `in_valid` is not sampled while `rst` is asserted.
- Latency: `in_last` accepted at edge N puts `out_valid=1` after edge N, visible in cycle N+1.
- Throughput: one operand per cycle in ACCUM.
- At least one dead input cycle follows each frame. The earliest next accept is the cycle after the output handshake.
- `in_ready` is a purely combinational function of registered `out_valid`. There is no combinational path from `in_valid` or `out_ready` to any output.
- Critical path: `in_data` through the 32-bit adder into `acc`/cout. This must close in one cycle with no extra pipelining.

## Structure
- Shared package holds:
  - the data width constant `DATA_W=32`;
  - the FSM state enum {ACCUM, HOLD};
  - a saturating-increment function used by both counters.
- One sub-module instance: the existing 32-bit Brent-Kung adder.
  - Its `a` connects to `acc`, `b` to `in_data`, `cin` ties to 0.
  - Its `s` and `cout` feed the next-state logic.
- No other sub-modules.

## Test plan
1. Reset then idle:
   - Assert `rst` asynchronously mid-cycle; all outputs take reset values immediately.
   - After release: `in_ready=1`, `out_valid=0` for 10 idle cycles.
2. Frame {1, 2, 3(last)} back-to-back:
   - `out_valid` rises the cycle after beat 3.
   - Outputs: `out_sum=6`, `out_carries=0`, `out_count=3`, `out_cnt_sat=0`.
3. Frame {0xFFFFFFFF, 0x1, 0xFFFFFFFF(last)}, with one bubble between beats 1 and 2:
   - Outputs: `out_sum=0xFFFFFFFF`, `out_carries=1`, `out_count=3`.
4. Backpressure:
   - Hold `out_ready=0` for 5 cycles after a result with `in_valid=1` and `in_data=9`.
   - Outputs stay stable and `in_ready=0`; no beat is accepted.
   - After `out_ready` pulses, the next frame {9(last)} gives `out_sum=9`, `out_count=1`.
5. `CNT_W=2`, frame of five 1s (last on fifth):
   - Outputs: `out_sum=5`, `out_count=3`, `out_cnt_sat=1`.
   - The following frame {4(last)} gives `out_cnt_sat=0`, `out_count=1`.
6. Reset mid-frame:
   - Accept {100, 200}, assert `rst` for 1 cycle, then send frame {7(last)}.
   - Outputs: `out_sum=7`, `out_count=1`, `out_carries=0`.
